// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a valid/ready request, a done pulse and a {C,S,Z} status register.
// Shifts and rotates iterate one bit per cycle; half mode confines work to the low HALF bits.
module seq_alu #(
  parameter int WIDTH = 20,
  parameter int HALF  = WIDTH / 2,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_c
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [WIDTH-1:0] HMASK =
    {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
  localparam logic [WIDTH-1:0] HTOP = HMASK ^ (HMASK >> 1);
  localparam logic [WIDTH-1:0] FTOP = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   ONE  = {{WIDTH{1'b0}}, 1'b1};

  state_t           state;
  logic [4:0]       opr;
  logic             md;
  logic [WIDTH-1:0] w;
  logic [WIDTH-1:0] bm;
  logic [SHW-1:0]   cnt;
  logic             sc;
  logic [2:0]       sr;

  logic [WIDTH-1:0] imask;
  logic [WIDTH-1:0] mask;
  logic             msb;
  logic [WIDTH-1:0] wn;
  logic             sn;

  assign imask    = mode ? '1 : HMASK;
  assign mask     = md ? '1 : HMASK;
  assign msb      = md ? w[WIDTH-1] : w[HALF-1];
  assign in_ready = (state == IDLE);
  assign flag_c   = sr[2];
  assign flag_s   = sr[1];
  assign flag_z   = sr[0];

  function automatic logic cbit(
    input logic [WIDTH:0] v,
    input logic           full
  );
    return full ? v[WIDTH] : v[HALF];
  endfunction

  // One-bit step of the working register; sn is the bit leaving the word.
  always_comb begin
    wn = w;
    sn = 1'b0;
    case (opr[1:0])
      2'd0: begin
        wn = (w << 1) & mask;
        sn = msb;
      end
      2'd1: begin
        wn = w >> 1;
        sn = w[0];
      end
      2'd2: begin
        wn = ((w << 1) | {{(WIDTH-1){1'b0}}, msb}) & mask;
        sn = msb;
      end
      default: begin
        wn = (w >> 1) | (w[0] ? (md ? FTOP : HTOP) : '0);
        sn = w[0];
      end
    endcase
  end

  logic [WIDTH:0]   wx, bx, cx, ar;
  logic [WIDTH-1:0] res, resm, outc, resd;
  logic             rc, rs, upd;
  logic [2:0]       nsr;

  assign wx = {1'b0, w};
  assign bx = {1'b0, bm};
  assign cx = {{WIDTH{1'b0}}, sr[2]};

  always_comb begin
    res  = w;
    resd = '0;
    rc   = 1'b0;
    upd  = 1'b1;
    ar   = '0;
    case (opr)
      5'd0:  res = ~w;
      5'd1:  res = w & bm;
      5'd2:  res = w | bm;
      5'd3:  res = w ^ bm;
      5'd4, 5'd5, 5'd6, 5'd7: rc = sc;
      5'd8:  ar = wx + ONE;
      5'd9:  ar = wx - ONE;
      5'd10: ar = wx + bx;
      5'd11: ar = wx + bx + cx;
      5'd12, 5'd15: ar = wx - bx;
      5'd13: ar = wx - bx - cx;
      5'd14: begin
        res  = bm;
        resd = w;
      end
      5'd16, 5'd17: ;
      default: upd = 1'b0;
    endcase
    if (opr >= 5'd8 && opr <= 5'd13 || opr == 5'd15) begin
      res = ar[WIDTH-1:0];
      rc  = cbit(ar, md);
    end
    resm = res & mask;
    rs   = md ? resm[WIDTH-1] : resm[HALF-1];
    nsr  = {rc, rs, ~|resm};
    outc = resm;
    if (opr == 5'd15) outc = w;
    if (opr == 5'd16) nsr = w[2:0];
    if (opr == 5'd17) nsr = sr ^ w[2:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_d     <= '0;
      sr        <= '0;
      opr       <= '0;
      md        <= 1'b0;
      w         <= '0;
      bm        <= '0;
      cnt       <= '0;
      sc        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: if (in_valid) begin
          opr   <= op;
          md    <= mode;
          w     <= a & imask;
          bm    <= b & imask;
          cnt   <= (op[4:2] == 3'b001) ? b[SHW-1:0] : '0;
          sc    <= 1'b0;
          state <= EXEC;
        end
        EXEC: if (cnt == '0) begin
          out_c     <= outc;
          out_d     <= resd;
          if (upd) sr <= nsr;
          out_valid <= 1'b1;
          state     <= DONE;
        end else begin
          w   <= wn;
          sc  <= sn;
          cnt <= cnt - 1'b1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table, busy/reset sequences and a
// randomized run against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic        mode;
  logic [19:0] a, b;
  logic        out_valid;
  logic [19:0] out_c, out_d;
  logic        flag_z, flag_s, flag_c;

  int ncmp = 0;
  int nbad = 0;

  seq_alu #(.WIDTH(20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mode(mode), .a(a), .b(b),
    .out_valid(out_valid), .out_c(out_c), .out_d(out_d),
    .flag_z(flag_z), .flag_s(flag_s), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: closed-form arithmetic on the effective width.
  task automatic model(input int o, input bit md,
                       input logic [19:0] av, input logic [19:0] bv,
                       inout logic [2:0] sr,
                       output logic [19:0] c, output logic [19:0] d,
                       output int lat);
    int ew, k, rr;
    longint m, am, bm, cin, r, fr;
    bit cf, upd;
    ew  = md ? 20 : 10;
    m   = (64'd1 << ew) - 1;
    am  = longint'(av) & m;
    bm  = longint'(bv) & m;
    cin = longint'(sr[2]);
    k   = int'(bv[4:0]);
    rr  = k % ew;
    d   = '0;
    lat = 2;
    cf  = 0;
    upd = 1;
    r   = am;
    case (o)
      0: r = ~am & m;
      1: r = am & bm;
      2: r = am | bm;
      3: r = am ^ bm;
      4: begin
        r  = (am << k) & m;
        cf = (k > 0 && k <= ew) ? bit'((am >> (ew - k)) & 1) : 0;
      end
      5: begin
        r  = am >> k;
        cf = (k > 0) ? bit'((am >> (k - 1)) & 1) : 0;
      end
      6: begin
        r  = ((am << rr) | (am >> (ew - rr))) & m;
        cf = (k > 0) ? bit'(r & 1) : 0;
      end
      7: begin
        r  = ((am >> rr) | (am << (ew - rr))) & m;
        cf = (k > 0) ? bit'((r >> (ew - 1)) & 1) : 0;
      end
      8:  begin cf = bit'((am + 1) >> ew); r = (am + 1) & m; end
      9:  begin cf = (am < 1); r = (am - 1) & m; end
      10: begin cf = bit'((am + bm) >> ew); r = (am + bm) & m; end
      11: begin
        cf = bit'((am + bm + cin) >> ew);
        r  = (am + bm + cin) & m;
      end
      12, 15: begin cf = (am < bm); r = (am - bm) & m; end
      13: begin cf = (am < bm + cin); r = (am - bm - cin) & m; end
      14: begin r = bm; d = av & 20'(m); end
      16, 17: ;
      default: upd = 0;
    endcase
    if (o >= 4 && o <= 7) lat += k;
    fr = r;
    c  = (o == 15) ? 20'(am) : 20'(r);
    if (o == 16) sr = av[2:0];
    else if (o == 17) sr = sr ^ av[2:0];
    else if (upd)
      sr = {cf, bit'((fr >> (ew - 1)) & 1), fr == 0};
  endtask

  // Issue one request, wait for the done pulse, return results and latency.
  task automatic run(input logic [4:0] o, input bit md,
                     input logic [19:0] av, input logic [19:0] bv,
                     output logic [19:0] gc, output logic [19:0] gd,
                     output logic [2:0] gsr, output int lat);
    @(negedge clk);
    chk("ready_idle", in_ready, 1'b1);
    chk("valid_idle", out_valid, 1'b0);
    in_valid = 1'b1;
    op = o; mode = md; a = av; b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 20'($urandom);
    b = 20'($urandom);
    op = 5'($urandom);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      if (in_ready !== 1'b0) begin
        chk("ready_busy", in_ready, 1'b0);
        break;
      end
      if (lat > 60) begin
        chk("done_timeout", lat, 0);
        break;
      end
    end
    gc  = out_c;
    gd  = out_d;
    gsr = {flag_c, flag_s, flag_z};
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        md;
    logic [19:0] a, b;
    logic [19:0] ec, ed;
    logic [2:0]  esr;
    int          elat;
  } vec_t;

  vec_t tv[$];

  initial begin
    logic [19:0] gc, gd, ec, ed;
    logic [2:0]  gsr, msr;
    int          lat, elat;
    logic [8:0]  pulses;
    int          late;

    tv.push_back('{5'd10, 1'b1, 20'hFFFFF, 20'h00001, 20'h00000, 20'h0, 3'b101, 2});
    tv.push_back('{5'd10, 1'b0, 20'hFFFFF, 20'h00001, 20'h00000, 20'h0, 3'b101, 2});
    tv.push_back('{5'd0,  1'b0, 20'h00000, 20'h00000, 20'h003FF, 20'h0, 3'b010, 2});
    tv.push_back('{5'd4,  1'b1, 20'h80001, 20'h00001, 20'h00002, 20'h0, 3'b100, 3});
    tv.push_back('{5'd4,  1'b1, 20'h80001, 20'h00004, 20'h00010, 20'h0, 3'b000, 6});
    tv.push_back('{5'd7,  1'b1, 20'h00001, 20'h00001, 20'h80000, 20'h0, 3'b110, 3});
    tv.push_back('{5'd7,  1'b0, 20'h00001, 20'h00001, 20'h00200, 20'h0, 3'b110, 3});
    tv.push_back('{5'd12, 1'b1, 20'h00000, 20'h00001, 20'hFFFFF, 20'h0, 3'b110, 2});
    tv.push_back('{5'd13, 1'b1, 20'h00005, 20'h00002, 20'h00002, 20'h0, 3'b000, 2});
    tv.push_back('{5'd16, 1'b1, 20'h00002, 20'h00000, 20'h00002, 20'h0, 3'b010, 2});
    tv.push_back('{5'd17, 1'b1, 20'h00007, 20'h00000, 20'h00007, 20'h0, 3'b101, 2});
    tv.push_back('{5'd8,  1'b0, 20'h003FF, 20'h00000, 20'h00000, 20'h0, 3'b101, 2});
    tv.push_back('{5'd9,  1'b1, 20'h00000, 20'h00000, 20'hFFFFF, 20'h0, 3'b110, 2});
    tv.push_back('{5'd11, 1'b1, 20'hFFFFE, 20'h00001, 20'h00000, 20'h0, 3'b101, 2});
    tv.push_back('{5'd14, 1'b1, 20'h12345, 20'hABCDE, 20'hABCDE, 20'h12345, 3'b010, 2});
    tv.push_back('{5'd15, 1'b1, 20'h00003, 20'h00005, 20'h00003, 20'h0, 3'b110, 2});
    tv.push_back('{5'd20, 1'b0, 20'hFFFFF, 20'h00000, 20'h003FF, 20'h0, 3'b110, 2});
    tv.push_back('{5'd4,  1'b1, 20'hFFFFF, 20'h00019, 20'h00000, 20'h0, 3'b001, 27});
    tv.push_back('{5'd6,  1'b0, 20'h00201, 20'h00003, 20'h0000C, 20'h0, 3'b000, 5});
    tv.push_back('{5'd5,  1'b1, 20'h00003, 20'h00001, 20'h00001, 20'h0, 3'b100, 3});
    tv.push_back('{5'd3,  1'b1, 20'hF0F0F, 20'h0F0F0, 20'hFFFFF, 20'h0, 3'b010, 2});

    rst = 1'b1;
    in_valid = 1'b0;
    op = '0; mode = 1'b1; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out_c", out_c, 20'h0);
    chk("rst_out_d", out_d, 20'h0);
    chk("rst_sr", {flag_c, flag_s, flag_z}, 3'b000);

    foreach (tv[i]) begin
      run(tv[i].op, tv[i].md, tv[i].a, tv[i].b, gc, gd, gsr, lat);
      chk($sformatf("vec%0d_c", i), gc, tv[i].ec);
      chk($sformatf("vec%0d_d", i), gd, tv[i].ed);
      chk($sformatf("vec%0d_sr", i), gsr, tv[i].esr);
      chk($sformatf("vec%0d_lat", i), lat, tv[i].elat);
    end

    // in_valid held through EXEC/DONE: accepts only from IDLE.
    @(negedge clk);
    in_valid = 1'b1;
    op = 5'd10; mode = 1'b1; a = 20'h1; b = 20'h1;
    pulses = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pulses[i] = out_valid;
    end
    in_valid = 1'b0;
    chk("busy_pulses", pulses, 9'h092);
    chk("busy_out_c", out_c, 20'h2);

    // Reset abandons an in-flight long shift.
    run(5'd12, 1'b1, 20'h0, 20'h1, gc, gd, gsr, lat);
    chk("pre_rst_sr", gsr, 3'b110);
    @(negedge clk);
    in_valid = 1'b1;
    op = 5'd4; mode = 1'b1; a = 20'hFFFFF; b = 20'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk($sformatf("shift_busy%0d", i), out_valid, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", in_ready, 1'b1);
    chk("abort_sr", {flag_c, flag_s, flag_z}, 3'b000);
    chk("abort_out_c", out_c, 20'h0);
    late = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    chk("abort_no_pulse", late, 0);

    // Randomized run; SR is zero after the reset above.
    msr = 3'b000;
    for (int n = 0; n < 300; n++) begin
      logic [4:0]  ro;
      logic        rm;
      logic [19:0] ra, rb;
      ro = 5'($urandom_range(0, 22));
      rm = 1'($urandom);
      ra = 20'($urandom);
      rb = 20'($urandom);
      model(int'(ro), rm, ra, rb, msr, ec, ed, elat);
      run(ro, rm, ra, rb, gc, gd, gsr, lat);
      chk($sformatf("rnd%0d_op%0d_c", n, ro), gc, ec);
      chk($sformatf("rnd%0d_op%0d_d", n, ro), gd, ed);
      chk($sformatf("rnd%0d_op%0d_sr", n, ro), gsr, msr);
      chk($sformatf("rnd%0d_op%0d_lat", n, ro), lat, elat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
